// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bundle for the instruction fetch queue.
// The queue takes the slave side; fetch/decode (or a bench) take the master side.
interface inst_fetch_queue_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int EXC_W       = 8
);
    localparam int PUSH_CW = $clog2(FETCH_WIDTH + 1);
    localparam int POP_CW  = $clog2(ISSUE_WIDTH + 1);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                         flush;
    logic                         push_valid;
    logic [PUSH_CW-1:0]           push_count;
    logic [31:0]                  push_pc;
    logic [FETCH_WIDTH*32-1:0]    push_inst;
    logic [EXC_W-1:0]             push_except;
    logic                         push_ready;
    logic [POP_CW-1:0]            pop_count;
    logic [ISSUE_WIDTH-1:0]       out_valid;
    logic [ISSUE_WIDTH*32-1:0]    out_inst;
    logic [ISSUE_WIDTH*32-1:0]    out_pc;
    logic [ISSUE_WIDTH*EXC_W-1:0] out_except;
    logic [CNT_W-1:0]             count;
    logic                         err_overflow;
    logic                         err_underflow;

    modport slave (
        input  flush, push_valid, push_count, push_pc, push_inst, push_except, pop_count,
        output push_ready, out_valid, out_inst, out_pc, out_except, count,
               err_overflow, err_underflow
    );

    modport master (
        output flush, push_valid, push_count, push_pc, push_inst, push_except, pop_count,
        input  push_ready, out_valid, out_inst, out_pc, out_except, count,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between IF and ID: multi-word fetch groups in,
// up to ISSUE_WIDTH oldest words presented combinationally to decode.
module inst_fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int EXC_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_V = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   FW_V    = (PTR_W+1)'(FETCH_WIDTH);

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [EXC_W-1:0] r_exc  [DEPTH];
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;
    logic             r_err_overflow;
    logic             r_err_underflow;

    logic [PTR_W:0]             w_count;
    logic [PTR_W:0]             w_pop_amt;
    logic [PTR_W:0]             w_push_amt;
    logic                       w_push_ready;
    logic                       w_push_acc;
    logic                       w_push_rej;
    logic                       w_underflow;
    logic [PTR_W-1:0]           w_wr_idx [FETCH_WIDTH];
    logic [ISSUE_WIDTH-1:0]     w_out_valid;
    logic [ISSUE_WIDTH*32-1:0]  w_out_inst;
    logic [ISSUE_WIDTH*32-1:0]  w_out_pc;
    logic [ISSUE_WIDTH*EXC_W-1:0] w_out_except;

    // Wrap bit in the pointers lets tail-head distinguish full from empty.
    assign w_count      = r_tail - r_head;
    assign w_push_ready = (DEPTH_V - w_count) >= FW_V;
    assign w_push_acc   = bus.push_valid & w_push_ready & ~bus.flush;
    assign w_push_rej   = bus.push_valid & ~w_push_ready & ~bus.flush;
    assign w_push_amt   = w_push_acc ? (PTR_W+1)'(bus.push_count) : (PTR_W+1)'(0);

    // Clamp the pop to what is actually held and flag over-consumption.
    always_comb begin
        w_pop_amt   = (PTR_W+1)'(0);
        w_underflow = 1'b0;
        if (int'(bus.pop_count) > int'(w_count)) begin
            w_pop_amt   = w_count;
            w_underflow = ~bus.flush;
        end else begin
            w_pop_amt   = (PTR_W+1)'(bus.pop_count);
            w_underflow = 1'b0;
        end
    end

    // Storage slot for each word of the incoming group, modulo DEPTH.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_wr_idx[i] = r_tail[PTR_W-1:0] + PTR_W'(i);
        end
    end

    // Entry storage; not reset because count masks stale contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!rst && w_push_acc && (i < int'(bus.push_count))) begin
                r_inst[w_wr_idx[i]] <= bus.push_inst[i*32 +: 32];
                r_pc[w_wr_idx[i]]   <= bus.push_pc + 32'(4 * i);
                r_exc[w_wr_idx[i]]  <= bus.push_except;
            end
        end
    end

    // Pointers and sticky error flags; flush empties but keeps the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= (PTR_W+1)'(0);
            r_tail          <= (PTR_W+1)'(0);
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_head <= (PTR_W+1)'(0);
            r_tail <= (PTR_W+1)'(0);
        end else begin
            r_tail <= r_tail + w_push_amt;
            r_head <= r_head + w_pop_amt;
            if (w_push_rej) begin
                r_err_overflow <= 1'b1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // Present head..head+ISSUE_WIDTH-1; slots beyond count read as zero.
    always_comb begin
        w_out_valid  = {ISSUE_WIDTH{1'b0}};
        w_out_inst   = {(ISSUE_WIDTH*32){1'b0}};
        w_out_pc     = {(ISSUE_WIDTH*32){1'b0}};
        w_out_except = {(ISSUE_WIDTH*EXC_W){1'b0}};
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (i < int'(w_count)) begin
                w_out_valid[i]              = 1'b1;
                w_out_inst[i*32 +: 32]      = r_inst[r_head[PTR_W-1:0] + PTR_W'(i)];
                w_out_pc[i*32 +: 32]        = r_pc[r_head[PTR_W-1:0] + PTR_W'(i)];
                w_out_except[i*EXC_W +: EXC_W] = r_exc[r_head[PTR_W-1:0] + PTR_W'(i)];
            end else begin
                w_out_valid[i] = 1'b0;
            end
        end
    end

    assign bus.push_ready    = w_push_ready;
    assign bus.count         = w_count;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_inst      = w_out_inst;
    assign bus.out_pc        = w_out_pc;
    assign bus.out_except    = w_out_except;
    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_underflow = r_err_underflow;
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised instruction buffer between the IF stage and the ID stage. It replaces the fixed two-slot "instruction left over" latch.
- Accepts fetch groups of up to FETCH_WIDTH words per cycle and presents up to ISSUE_WIDTH oldest words to decode.
- Decode consumes 0..ISSUE_WIDTH words per cycle. This decouples fetch bandwidth from issue width and absorbs partial issue, e.g. when the second slot of a dual-issue pair is not taken.
- Flushed on exception or branch redirect.

Parameters:
FETCH_WIDTH, 2, words delivered per fetch group (1..4)
ISSUE_WIDTH, 2, words presented to decode per cycle (1..4)
DEPTH, 8, entries; power of 2, >= 2*FETCH_WIDTH
EXC_W, 8, width of per-group fetch exception tag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all contents this cycle
push_valid  in  1  fetch group present
push_count  in  $clog2(FETCH_WIDTH+1)  valid words in group, 1..FETCH_WIDTH
push_pc  in  32  PC of word 0; word i has PC push_pc+4*i
push_inst  in  FETCH_WIDTH*32  instruction words, word 0 in LSBs
push_except  in  EXC_W  fetch exception tag, copied to every word of the group
push_ready  out  1  free entries >= FETCH_WIDTH
pop_count  in  $clog2(ISSUE_WIDTH+1)  words consumed from head this cycle
out_valid  out  ISSUE_WIDTH  thermometer; bit i set if head+i holds data
out_inst  out  ISSUE_WIDTH*32  words at head..head+ISSUE_WIDTH-1
out_pc  out  ISSUE_WIDTH*32  matching PCs
out_except  out  ISSUE_WIDTH*EXC_W  matching exception tags
count  out  $clog2(DEPTH+1)  occupied entries
err_overflow  out  1  sticky: push attempted while push_ready=0
err_underflow  out  1  sticky: pop_count exceeded valid entries

Behaviour:
- Storage: circular array of DEPTH entries {inst, pc, except}. Head and tail pointers are log2(DEPTH)+1 bits; the extra MSB is the wrap bit. count = tail-head.
- Outputs are combinational reads of head..head+ISSUE_WIDTH-1 (modulo DEPTH).
  - Entries with index >= count: out_valid bit 0, inst 0 (nop), pc 0, except 0.
  - A word pushed in cycle N is visible on out_* in cycle N+1 (no bypass).
- push_ready = (DEPTH-count >= FETCH_WIDTH). It depends on the current state only, not on this cycle's pop.
- Accepted push (push_valid & push_ready & ~flush): writes push_count words at tail..tail+push_count-1; tail += push_count.
  - push_count = 0 with push_valid: no-op, no error.
- Pop: head += min(pop_count, count).
  - pop_count > count sets err_underflow; head advances only by count.
- Simultaneous push and pop in one cycle: both take effect; count_next = count + pushed - popped.
- Rejected push (push_valid & ~push_ready & ~flush): data dropped, err_overflow set.
- Flush priority: flush=1 sets head=tail=0 and count=0; push and pop are ignored that cycle.
  - Output is empty next cycle.
  - Error flags are not cleared by flush.
- Reset (rst=1 at clk edge): head=tail=0, count=0, err_overflow=0, err_underflow=0.
  - Storage is not cleared; it is masked by count.
  - After reset: push_ready=1, out_valid=0, out_* all zero.
  - rst has priority over flush, push and pop. Reset mid-operation discards all contents.
- Wrap-around: indices are taken modulo DEPTH. A group may straddle the array end, e.g. tail=7 and 2 words with DEPTH=8 write entries 7 and 0.
- Full (count=DEPTH): out_valid all ones (if ISSUE_WIDTH <= DEPTH), push_ready=0.
- Empty: out_valid=0; pop_count=0 required.
- Ordering: words leave in exact push order. Word i of a group always precedes word i+1.

Test Plan:
- Reset, then push_count=2, pc=0x80000000, inst {0x24020001,0x24030002}; pop_count=0 -> next cycle out_valid=2'b11, out_pc={0x80000004,0x80000000}, count=2.
- From the state above, pop_count=1 for one cycle -> out_valid=2'b01, out_inst[31:0]=0x24030002, out_pc[31:0]=0x80000004, count=1.
- Push 2 words every cycle with no pop (DEPTH=8) -> push_ready drops at count=8. Further push -> data dropped, err_overflow=1, count stays 8.
- Drain to tail=7, head=7 (count=0), push 2 words, pop 2 next cycle -> entries 7 then 0 read in order; head=tail=9 (wrapped); count=0.
- count=5 with a simultaneous push of 2 and flush=1 -> next cycle count=0, out_valid=0, push_ready=1; the pushed words never appear.
- count=1, pop_count=2 -> count=0, err_underflow=1. Assert rst -> both error flags clear, count=0.
